// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receive path.
// Frame bit positions, prefix codes and event word layout.
package ps2_pkg;
    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [3:0] PS2_BIT_START = 4'd0;
    localparam logic [3:0] PS2_BIT_D7    = 4'd8;
    localparam logic [3:0] PS2_BIT_PAR   = 4'd9;
    localparam logic [3:0] PS2_BIT_STOP  = 4'd10;
    localparam int         EV_BRK        = 9;
    localparam int         EV_EXT        = 8;
    localparam int         EV_W          = 10;
endpackage

// File: rtl/ps2_frame_shifter.sv
// Bit counter, LSB-first shift register and odd-parity accumulator
// for one 11-bit PS/2 device frame.
module ps2_frame_shifter
    import ps2_pkg::*;
(
    input  logic       ps2_clkn,
    input  logic       rst,
    input  logic       ps2_data,
    output logic       at_stop,
    output logic       busy,
    output logic [7:0] code,
    output logic       par_ok
);

    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic       par;

    always_ff @(posedge ps2_clkn) begin
        if (rst) begin
            bit_cnt <= PS2_BIT_START;
            shift   <= '0;
            par     <= 1'b0;
        end else begin
            unique case (1'b1)
                (bit_cnt == PS2_BIT_START): begin
                    // A high line while idle is ignored, so we resync on the next low.
                    if (!ps2_data) begin
                        bit_cnt <= 4'd1;
                        par     <= 1'b0;
                    end
                end
                (bit_cnt >= 4'd1 && bit_cnt <= PS2_BIT_D7): begin
                    shift   <= {ps2_data, shift[7:1]};
                    par     <= par ^ ps2_data;
                    bit_cnt <= bit_cnt + 4'd1;
                end
                (bit_cnt == PS2_BIT_PAR): begin
                    par     <= par ^ ps2_data;
                    bit_cnt <= PS2_BIT_STOP;
                end
                default: begin
                    bit_cnt <= PS2_BIT_START;
                end
            endcase
        end
    end

    assign at_stop = (bit_cnt == PS2_BIT_STOP);
    assign busy    = (bit_cnt != PS2_BIT_START);
    assign code    = shift;
    assign par_ok  = par;

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 receive front end: deframes, validates, folds E0/F0 prefixes
// and writes one event word per key code into the external FIFO.
module ps2_rx_decoder
    import ps2_pkg::*;
#(
    parameter bit CHECK_PARITY  = 1'b1,
    parameter bit DECODE_PREFIX = 1'b1,
    parameter int CNT_W         = 8
) (
    input  logic             ps2_clkn,
    input  logic             rst,
    input  logic             ps2_data,
    input  logic             ev_full,
    output logic [EV_W-1:0]  ev_data,
    output logic             ev_wr,
    output logic             busy,
    output logic [CNT_W-1:0] par_err_cnt,
    output logic [CNT_W-1:0] frm_err_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic       at_stop;
    logic [7:0] code;
    logic       par_ok;
    logic       par_good;
    logic       is_ext;
    logic       is_brk;
    logic       ext;
    logic       brk;

    ps2_frame_shifter u_shifter (
        .ps2_clkn (ps2_clkn),
        .rst      (rst),
        .ps2_data (ps2_data),
        .at_stop  (at_stop),
        .busy     (busy),
        .code     (code),
        .par_ok   (par_ok)
    );

    assign par_good = par_ok | !CHECK_PARITY;
    assign is_ext   = DECODE_PREFIX && (code == PS2_PFX_EXT);
    assign is_brk   = DECODE_PREFIX && (code == PS2_PFX_BRK);

    // Combinational so the FIFO captures the event on the stop-bit edge itself.
    assign ev_wr   = at_stop & ps2_data & par_good
                   & !is_ext & !is_brk & !ev_full;
    assign ev_data = {brk, ext, code};

    always_ff @(posedge ps2_clkn) begin
        if (rst) begin
            ext         <= 1'b0;
            brk         <= 1'b0;
            par_err_cnt <= '0;
            frm_err_cnt <= '0;
            ovf_cnt     <= '0;
        end else if (at_stop) begin
            if (!ps2_data) begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (frm_err_cnt != CNT_MAX)
                    frm_err_cnt <= frm_err_cnt + 1'b1;
            end else if (!par_good) begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (par_err_cnt != CNT_MAX)
                    par_err_cnt <= par_err_cnt + 1'b1;
            end else if (is_ext) begin
                ext <= 1'b1;
            end else if (is_brk) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (ev_full && ovf_cnt != CNT_MAX)
                    ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end

endmodule
